// File: rtl/updown_ctr_pkg.sv
// Shared key indices, key vector type and count-mode encoding for the up/down key counter.
package updown_ctr_pkg;

  localparam int unsigned NUM_KEYS = 3;
  localparam int unsigned KEY_INC  = 0;
  localparam int unsigned KEY_DEC  = 1;
  localparam int unsigned KEY_CLR  = 2;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-FF synchroniser, debounce counter, accepted level and press strobe.
module key_debouncer #(
  parameter int unsigned DEB_DELAY = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEB_DELAY);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_DELAY - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Bring the raw key into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_i;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEB_DELAY consecutive differing samples;
  // the strobe is registered alongside the rising acceptance, so it lands in
  // the first cycle the new high level is visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      stable_o <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      press_o <= 1'b0;
      if (s2 == stable_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        stable_o <= s2;
        press_o  <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/updown_key_counter.sv
// Debounced up/down/clear event counter with programmable step and wrap or saturate mode.
module updown_key_counter
  import updown_ctr_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned DEB_DELAY   = 250,
  parameter int unsigned STEP        = 1,
  parameter int unsigned SAT_MODE    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   inc_key_i,
  input  logic                   dec_key_i,
  input  logic                   clr_key_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   limit_o,
  output logic [2:0]             pressed_o
);

  localparam int unsigned          AW       = COUNT_WIDTH + 1;
  localparam logic [AW-1:0]        STEP_EXT = AW'(STEP);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam count_mode_e          MODE     = (SAT_MODE != 0) ? MODE_SAT : MODE_WRAP;

  key_vec_t                raw_keys;
  key_vec_t                stable;
  key_vec_t                press;
  logic [AW-1:0]           sum;
  logic [AW-1:0]           diff;
  logic [COUNT_WIDTH-1:0]  count_nxt;
  logic                    limit_nxt;

  assign raw_keys = {clr_key_i, dec_key_i, inc_key_i};

  // One debouncer per key.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    key_debouncer #(
      .DEB_DELAY(DEB_DELAY)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .key_i   (raw_keys[k]),
      .stable_o(stable[k]),
      .press_o (press[k])
    );
  end

  // Debounced levels come straight from the debouncer state flops.
  assign pressed_o = stable;

  // Priority clr > (inc&dec cancel) > inc > dec; carry/borrow taken from the extra bit.
  always_comb begin
    sum       = {1'b0, count_o} + STEP_EXT;
    diff      = {1'b0, count_o} - STEP_EXT;
    count_nxt = count_o;
    limit_nxt = 1'b0;
    if (press[KEY_CLR]) begin
      count_nxt = '0;
    end else if (press[KEY_INC] && !press[KEY_DEC]) begin
      count_nxt = sum[COUNT_WIDTH-1:0];
      if (sum[COUNT_WIDTH]) begin
        limit_nxt = 1'b1;
        if (MODE == MODE_SAT) count_nxt = CNT_MAX;
      end
    end else if (press[KEY_DEC] && !press[KEY_INC]) begin
      count_nxt = diff[COUNT_WIDTH-1:0];
      if (diff[COUNT_WIDTH]) begin
        limit_nxt = 1'b1;
        if (MODE == MODE_SAT) count_nxt = '0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
      limit_o <= 1'b0;
    end else begin
      count_o <= count_nxt;
      limit_o <= limit_nxt;
    end
  end

endmodule
